// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// hands each returned instruction to decode over a valid/ready handshake.
module ifu_fetch #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            drop_q, drop_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;

    logic [XLEN-1:0] redirect_tgt;
    logic            req_fire;

    assign redirect_tgt = redirect_pc & ~XLEN'(3);
    assign req_fire     = (state_q == ST_REQ) && imem_req_ready;

    // Outputs decode only flopped state, so nothing combinational reaches them from inputs.
    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == ST_HOLD);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            req_pc_q  <= '0;
            drop_q    <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            drop_q    <= drop_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        drop_d    = drop_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;

        case (state_q)
            ST_REQ: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = ST_WAIT;
                    // Request already left with the old pc; its response must be discarded.
                    if (redirect_valid) drop_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        inst_d    = imem_rsp_data;
                        inst_pc_d = req_pc_q;
                        state_d   = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (inst_ready || redirect_valid) state_d = ST_REQ;
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        // Redirect target always wins over the sequential pc+4.
        if (redirect_valid) pc_d = redirect_tgt;
    end

endmodule
